// File: rtl/enemy_step_seq_if.sv
// Enemy/player coordinate bus into the step sequencer and its per-enemy animation/hit outputs.
interface enemy_step_seq_if #(
  parameter int N_ENEMY = 4,
  parameter int COORD_W = 9,
  parameter int STEP_W  = 2
);
  logic [N_ENEMY*COORD_W-1:0] enemy_x;
  logic [N_ENEMY*COORD_W-1:0] enemy_y;
  logic [N_ENEMY-1:0]         enemy_alive;
  logic [COORD_W-1:0]         player_x;
  logic [COORD_W-1:0]         player_y;
  logic [N_ENEMY*STEP_W-1:0]  step_count;
  logic [N_ENEMY-1:0]         walking;
  logic [N_ENEMY-1:0]         hit_pulse;

  modport master (
    output enemy_x, enemy_y, enemy_alive, player_x, player_y,
    input  step_count, walking, hit_pulse
  );

  modport slave (
    input  enemy_x, enemy_y, enemy_alive, player_x, player_y,
    output step_count, walking, hit_pulse
  );
endinterface

// File: rtl/enemy_step_seq.sv
// Multi-enemy walk-animation sequencer: one independent IDLE/WALK channel per enemy,
// cycling the sprite step while away from the player and pulsing hits while near.
module enemy_step_ch #(
  parameter int COORD_W         = 9,
  parameter int STEPS           = 4,
  parameter int NEAR_DIST       = 2,
  parameter int FRAMES_PER_STEP = 1,
  parameter int ATTACK_FRAMES   = 8,
  localparam int STEP_W         = $clog2(STEPS)
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] ex,
  input  logic [COORD_W-1:0] ey,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               alive,
  output logic [STEP_W-1:0]  step,
  output logic               walking,
  output logic               hit
);
  localparam int PSC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int ATK_W = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;
  localparam logic [PSC_W-1:0]   PSC_LAST  = PSC_W'(FRAMES_PER_STEP - 1);
  localparam logic [ATK_W-1:0]   ATK_LAST  = ATK_W'(ATTACK_FRAMES - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [COORD_W:0]   NEAR_LIM  = (COORD_W+1)'(NEAR_DIST);

  typedef enum logic {IDLE, WALK} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [ATK_W-1:0]   atk_q, atk_d;
  logic               hit_q, hit_d;

  // One extra bit keeps the difference from wrapping at the screen edge.
  logic [COORD_W:0] dx, dy;
  logic             near;
  assign dx   = (ex >= px) ? ({1'b0, ex} - {1'b0, px}) : ({1'b0, px} - {1'b0, ex});
  assign dy   = (ey >= py) ? ({1'b0, ey} - {1'b0, py}) : ({1'b0, py} - {1'b0, ey});
  assign near = (dx <= NEAR_LIM) && (dy <= NEAR_LIM);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    psc_d   = psc_q;
    atk_d   = atk_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        step_d = '0;
        psc_d  = '0;
        if (!alive) begin
          atk_d = '0;
        end else if (!near) begin
          state_d = WALK;
          step_d  = STEP_W'(1);
          atk_d   = '0;
        end else if (atk_q == ATK_LAST) begin
          hit_d = 1'b1;
          atk_d = '0;
        end else begin
          atk_d = atk_q + ATK_W'(1);
        end
      end
      WALK: begin
        // Proximity is ignored here: a started walk cycle always runs back to step 0.
        atk_d = '0;
        if (!alive) begin
          state_d = IDLE;
          step_d  = '0;
          psc_d   = '0;
        end else if (psc_q != PSC_LAST) begin
          psc_d = psc_q + PSC_W'(1);
        end else begin
          psc_d = '0;
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = IDLE;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      psc_q   <= '0;
      atk_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      psc_q   <= psc_d;
      atk_q   <= atk_d;
      hit_q   <= hit_d;
    end
  end

  assign step    = step_q;
  assign walking = (state_q == WALK);
  assign hit     = hit_q;
endmodule

module enemy_step_seq #(
  parameter int N_ENEMY         = 4,
  parameter int COORD_W         = 9,
  parameter int STEPS           = 4,
  parameter int NEAR_DIST       = 2,
  parameter int FRAMES_PER_STEP = 1,
  parameter int ATTACK_FRAMES   = 8,
  localparam int STEP_W         = $clog2(STEPS)
) (
  input logic              frame_clk,
  input logic              Reset,
  enemy_step_seq_if.slave  bus
);
  logic [N_ENEMY-1:0][STEP_W-1:0] step_w;
  logic [N_ENEMY-1:0]             walk_w;
  logic [N_ENEMY-1:0]             hit_w;

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_ch
    enemy_step_ch #(
      .COORD_W(COORD_W), .STEPS(STEPS), .NEAR_DIST(NEAR_DIST),
      .FRAMES_PER_STEP(FRAMES_PER_STEP), .ATTACK_FRAMES(ATTACK_FRAMES)
    ) u_ch (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .ex        (bus.enemy_x[i*COORD_W +: COORD_W]),
      .ey        (bus.enemy_y[i*COORD_W +: COORD_W]),
      .px        (bus.player_x),
      .py        (bus.player_y),
      .alive     (bus.enemy_alive[i]),
      .step      (step_w[i]),
      .walking   (walk_w[i]),
      .hit       (hit_w[i])
    );
  end

  assign bus.step_count = step_w;
  assign bus.walking    = walk_w;
  assign bus.hit_pulse  = hit_w;
endmodule

// File: tb/tb_enemy_step_seq.sv
// Randomized bench for enemy_step_seq: two instances (1 and 3 frames per step) against a
// frame-counting reference model.
module tb_enemy_step_seq;
  localparam int NE = 4, CW = 9, SW = 2, STEPS = 4, AF = 8;

  logic frame_clk = 1'b0;
  logic rst = 1'b1;
  always #5 frame_clk = ~frame_clk;

  logic [NE*CW-1:0] ex_v = '0, ey_v = '0;
  logic [NE-1:0]    al_v = '0;
  logic [CW-1:0]    px_v = '0, py_v = '0;

  enemy_step_seq_if #(.N_ENEMY(NE), .COORD_W(CW), .STEP_W(SW)) bus0 ();
  enemy_step_seq_if #(.N_ENEMY(NE), .COORD_W(CW), .STEP_W(SW)) bus1 ();

  assign bus0.enemy_x = ex_v;  assign bus1.enemy_x = ex_v;
  assign bus0.enemy_y = ey_v;  assign bus1.enemy_y = ey_v;
  assign bus0.enemy_alive = al_v;  assign bus1.enemy_alive = al_v;
  assign bus0.player_x = px_v; assign bus1.player_x = px_v;
  assign bus0.player_y = py_v; assign bus1.player_y = py_v;

  enemy_step_seq #(.N_ENEMY(NE), .COORD_W(CW), .STEPS(STEPS), .NEAR_DIST(2),
                   .FRAMES_PER_STEP(1), .ATTACK_FRAMES(AF))
    u_dut1 (.frame_clk(frame_clk), .Reset(rst), .bus(bus0));
  enemy_step_seq #(.N_ENEMY(NE), .COORD_W(CW), .STEPS(STEPS), .NEAR_DIST(2),
                   .FRAMES_PER_STEP(3), .ATTACK_FRAMES(AF))
    u_dut3 (.frame_clk(frame_clk), .Reset(rst), .bus(bus1));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: walk is tracked as frames elapsed since the walk began; attack as the length
  // of the current run of near frames spent idle and alive.
  int m_walk[2][NE], m_t[2][NE], m_run[2][NE], m_hit[2][NE];

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step(input int d);
    int fps, ex, ey, nr;
    fps = (d == 0) ? 1 : 3;
    for (int i = 0; i < NE; i++) begin
      ex = int'(ex_v[i*CW +: CW]);
      ey = int'(ey_v[i*CW +: CW]);
      nr = (absdiff(ex, int'(px_v)) <= 2 && absdiff(ey, int'(py_v)) <= 2) ? 1 : 0;
      m_hit[d][i] = 0;
      if (rst) begin
        m_walk[d][i] = 0; m_t[d][i] = 0; m_run[d][i] = 0;
      end else if (m_walk[d][i] != 0) begin
        m_run[d][i] = 0;
        if (!al_v[i]) begin
          m_walk[d][i] = 0; m_t[d][i] = 0;
        end else begin
          m_t[d][i]++;
          if (m_t[d][i] == (STEPS - 1) * fps) begin
            m_walk[d][i] = 0; m_t[d][i] = 0;
          end
        end
      end else if (!al_v[i]) begin
        m_run[d][i] = 0;
      end else if (nr == 0) begin
        m_walk[d][i] = 1; m_t[d][i] = 0; m_run[d][i] = 0;
      end else begin
        m_run[d][i]++;
        m_hit[d][i] = (m_run[d][i] % AF == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic frame();
    int fps, exp_step;
    logic [NE*SW-1:0] sc;
    logic [NE-1:0]    wk, hp;
    @(posedge frame_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      fps = (d == 0) ? 1 : 3;
      sc  = (d == 0) ? bus0.step_count : bus1.step_count;
      wk  = (d == 0) ? bus0.walking    : bus1.walking;
      hp  = (d == 0) ? bus0.hit_pulse  : bus1.hit_pulse;
      for (int i = 0; i < NE; i++) begin
        exp_step = (m_walk[d][i] != 0) ? 1 + m_t[d][i] / fps : 0;
        chk($sformatf("step fps%0d ch%0d", fps, i), int'(sc[i*SW +: SW]), exp_step);
        chk($sformatf("walking fps%0d ch%0d", fps, i), int'(wk[i]), m_walk[d][i]);
        chk($sformatf("hit fps%0d ch%0d", fps, i), int'(hp[i]), m_hit[d][i]);
      end
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic set_en(input int i, input int x, input int y, input logic a);
    ex_v[i*CW +: CW] = CW'(x);
    ey_v[i*CW +: CW] = CW'(y);
    al_v[i] = a;
  endtask

  initial begin
    int o;
    rst = 1'b1;
    frames(2);
    rst = 1'b0;
    px_v = 9'd10; py_v = 9'd10;
    set_en(0, 100, 100, 1'b1);   // far walker
    set_en(1, 200, 200, 1'b0);   // dead
    set_en(2, 12, 8, 1'b1);      // |dx|=|dy|=2: near, accumulates hits
    set_en(3, 13, 10, 1'b1);     // |dx|=3: walks
    frames(10);
    set_en(0, 10, 10, 1'b1);     // enemy steps onto the player mid-walk
    frames(8);
    al_v[1] = 1'b1;
    frames(2);
    al_v[1] = 1'b0;              // killed mid-walk
    frames(1);
    al_v[1] = 1'b1;              // revived while far
    frames(6);
    px_v = 9'd511; py_v = 9'd5;
    set_en(3, 0, 5, 1'b1);       // 0 vs 511 must not wrap into near
    set_en(2, 509, 7, 1'b1);
    frames(12);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        px_v = CW'($urandom_range(0, 511));
        py_v = CW'($urandom_range(0, 511));
      end
      for (int i = 0; i < NE; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 2) != 0) begin
            o = $urandom_range(0, 8);
            ex_v[i*CW +: CW] = CW'((int'(px_v) + o - 4) & 511);
            o = $urandom_range(0, 8);
            ey_v[i*CW +: CW] = CW'((int'(py_v) + o - 4) & 511);
          end else begin
            ex_v[i*CW +: CW] = CW'($urandom_range(0, 511));
            ey_v[i*CW +: CW] = CW'($urandom_range(0, 511));
          end
          al_v[i] = ($urandom_range(0, 7) != 0);
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      frame();
    end
    rst = 1'b0;

    px_v = 9'd10; py_v = 9'd10;
    for (int i = 0; i < NE; i++) set_en(i, 100 + 50 * i, 300, 1'b1);
    frames(4);
    rst = 1'b1;                  // reset in the middle of every walk
    frames(1);
    rst = 1'b0;
    frames(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
